// File: rtl/digit_conv_ctrl.sv
// Sequential 8,4,-2,-1 to BCD word converter: one shared digit converter is
// stepped over the captured word, least-significant digit first.
module digit_conv_ctrl #(
  parameter int NDIG = 4
) (
  input  logic                clock,
  input  logic                reset_b,
  input  logic                start,
  input  logic [4*NDIG-1:0]   din,
  output logic                busy,
  output logic                done,
  output logic [4*NDIG-1:0]   dout,
  output logic [NDIG-1:0]     err_mask
);

  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt;
  logic [4*NDIG-1:0]   cap;
  logic [3:0]          cur_code;
  logic [3:0]          cur_bcd;
  logic                cur_err;
  logic                last;

  assign last     = (cnt == CW'(NDIG - 1));
  assign cur_code = cap[{cnt, 2'b00} +: 4];

  // The single shared converter; every code outside the ten legal ones maps
  // to 4'hF and raises the error flag.
  always_comb begin
    cur_err = 1'b0;
    cur_bcd = 4'hF;
    case (cur_code)
      4'b0000: cur_bcd = 4'd0;
      4'b0111: cur_bcd = 4'd1;
      4'b0110: cur_bcd = 4'd2;
      4'b0101: cur_bcd = 4'd3;
      4'b0100: cur_bcd = 4'd4;
      4'b1011: cur_bcd = 4'd5;
      4'b1010: cur_bcd = 4'd6;
      4'b1001: cur_bcd = 4'd7;
      4'b1000: cur_bcd = 4'd8;
      4'b1111: cur_bcd = 4'd9;
      default: cur_err = 1'b1;
    endcase
  end

  // NOTE: state register uses non-blocking assignment so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = CONV;
      CONV: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the captured word is a plain register, not a memory, so it is
  // cleared by reset along with the visible outputs.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      cap      <= '0;
      cnt      <= '0;
      dout     <= '0;
      err_mask <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cap      <= din;
          cnt      <= '0;
          dout     <= '0;
          err_mask <= '0;
        end
        CONV: begin
          dout[{cnt, 2'b00} +: 4] <= cur_bcd;
          err_mask[cnt]           <= cur_err;
          // Counter parks on the last index instead of wrapping.
          if (!last) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_conv_ctrl.sv
// Self-checking bench for digit_conv_ctrl: stimulus pushes predicted results
// into a scoreboard, a monitor pops and compares on each done pulse.
module tb_digit_conv_ctrl;

  localparam int NDIG = 4;

  logic                clock;
  logic                reset_b;
  logic                start;
  logic [4*NDIG-1:0]   din;
  logic                busy;
  logic                done;
  logic [4*NDIG-1:0]   dout;
  logic [NDIG-1:0]     err_mask;

  digit_conv_ctrl #(.NDIG(NDIG)) dut (
    .clock    (clock),
    .reset_b  (reset_b),
    .start    (start),
    .din      (din),
    .busy     (busy),
    .done     (done),
    .dout     (dout),
    .err_mask (err_mask)
  );

  typedef struct {
    int                due;
    logic [4*NDIG-1:0] dout;
    logic [NDIG-1:0]   mask;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Digit value is its signed weighted sum; legal codes are exactly those
  // whose weighted value falls in 0..9.
  function automatic exp_t model(input logic [4*NDIG-1:0] d, input int due);
    exp_t r;
    r.due  = due;
    r.dout = '0;
    r.mask = '0;
    for (int i = 0; i < NDIG; i++) begin
      logic [3:0] nib;
      int v;
      nib = d[4*i +: 4];
      v = 8*int'(nib[3]) + 4*int'(nib[2]) - 2*int'(nib[1]) - int'(nib[0]);
      if (v >= 0 && v <= 9) r.dout[4*i +: 4] = 4'(v);
      else begin
        r.dout[4*i +: 4] = 4'hF;
        r.mask[i]        = 1'b1;
      end
    end
    return r;
  endfunction

  always @(negedge clock) begin
    if (reset_b) begin
      if (done) begin
        if (sb.size() == 0) check("spurious_done", done, 1'b0);
        else begin
          mon_e = sb.pop_front();
          check("done_cycle", 64'(cyc), 64'(mon_e.due));
          check("dout", dout, mon_e.dout);
          check("err_mask", err_mask, mon_e.mask);
        end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        check("done_missing", done, 1'b1);
        void'(sb.pop_front());
      end
    end
  end

  // Issues one conversion; returns on the falling edge where the DUT is back
  // in IDLE, so a following call is accepted on the very next edge.
  task automatic convert(input logic [4*NDIG-1:0] d, input bit hold,
                         input bit scramble, input int gap);
    int   k;
    exp_t e;
    repeat (gap) @(negedge clock);
    start = 1'b1;
    din   = d;
    k     = cyc + 1;
    e     = model(d, k + NDIG);
    sb.push_back(e);
    @(negedge clock);
    if (!hold) start = 1'b0;
    if (scramble) begin
      din   = 16'hFFFF;
      start = 1'b1;
    end
    while (cyc < k + NDIG + 1) begin
      check("busy", busy, (cyc <= k + NDIG - 1));
      @(negedge clock);
      if (scramble && cyc == k + 2) start = 1'b0;
    end
    check("hold_dout", dout, e.dout);
    check("hold_err_mask", err_mask, e.mask);
  endtask

  task automatic reset_abort();
    start   = 1'b1;
    din     = 16'h1B4E;
    @(negedge clock);
    start   = 1'b0;
    @(negedge clock);
    #2 reset_b = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dout", dout, '0);
    check("rst_err_mask", err_mask, '0);
    @(negedge clock);
    reset_b = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_b = 1'b0;
    start   = 1'b0;
    din     = '0;
    #1;
    check("init_busy", busy, 1'b0);
    check("init_done", done, 1'b0);
    check("init_dout", dout, '0);
    check("init_err_mask", err_mask, '0);
    @(negedge clock);
    @(negedge clock);
    reset_b = 1'b1;

    convert(16'hF870, 1'b0, 1'b0, 1);
    convert(16'h1B4E, 1'b0, 1'b0, 2);
    convert(16'h0000, 1'b0, 1'b1, 1);
    reset_abort();
    convert(16'h8BB7, 1'b0, 1'b0, 0);

    for (int rep = 0; rep < 3; rep++) convert(16'h4567, 1'b1, 1'b0, 0);
    start = 1'b0;

    for (int code = 0; code < 16; code++)
      convert(16'(code), 1'b0, 1'b0, code % 2);

    for (int n = 0; n < 25; n++)
      convert(16'($urandom), 1'b0, 1'b0, int'($urandom_range(0, 2)));

    repeat (10) @(negedge clock);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
